// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Requester and RAM-side signal bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iren;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              idone;

  logic              dren;
  logic              dwen;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              ddone;

  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
    output iload, idone, dload, ddone, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
    input  iload, idone, dload, ddone, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Fetch/data arbiter for a single-ported RAM.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            RST,
  mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_store_q, req_store_d;
  logic              req_write_q, req_write_d;

  logic data_pend;
  logic starve_hit;

  always_comb begin
    data_pend  = bus.dren | bus.dwen;
    starve_hit = data_pend && bus.iren && (starve_cnt_q == STARVE_LIM);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      req_addr_q   <= '0;
      req_store_q  <= '0;
      req_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      req_addr_q   <= req_addr_d;
      req_store_q  <= req_store_d;
      req_write_q  <= req_write_d;
    end
  end

  // Operands are captured only at the grant edge; requester changes during BUSY are ignored.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    req_addr_d   = req_addr_q;
    req_store_d  = req_store_q;
    req_write_d  = req_write_q;
    case (state_q)
      IDLE: begin
        if (starve_hit || (!data_pend && bus.iren)) begin
          state_d      = I_BUSY;
          req_addr_d   = bus.iaddr;
          req_write_d  = 1'b0;
          starve_cnt_d = '0;
        end else if (data_pend) begin
          state_d     = D_BUSY;
          req_addr_d  = bus.daddr;
          req_store_d = bus.dstore;
          req_write_d = bus.dwen;
          if (!bus.iren) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.ram_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM controls depend on state and captured registers only, never on requester inputs.
  always_comb begin
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_store = '0;
    bus.idone     = 1'b0;
    bus.iload     = '0;
    bus.ddone     = 1'b0;
    bus.dload     = '0;
    case (state_q)
      I_BUSY: begin
        bus.ram_ren  = 1'b1;
        bus.ram_addr = req_addr_q;
        if (bus.ram_ready) begin
          bus.idone = 1'b1;
          bus.iload = bus.ram_load;
        end
      end
      D_BUSY: begin
        bus.ram_wen   = req_write_q;
        bus.ram_ren   = !req_write_q;
        bus.ram_addr  = req_addr_q;
        bus.ram_store = req_store_q;
        if (bus.ram_ready) begin
          bus.ddone = 1'b1;
          bus.dload = req_write_q ? '0 : bus.ram_load;
        end
      end
      default: ;
    endcase
  end

  a_one_done: assert property (@(posedge CLK) disable iff (RST) !(bus.idone && bus.ddone));
  a_idle_quiet: assert property (@(posedge CLK) disable iff (RST)
    (state_q == IDLE) |-> !(bus.ram_ren || bus.ram_wen));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Scoreboard bench for mem_arbiter with a latency-programmable RAM model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] LOAD_KEY = 32'h2108_0044;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int   lat;
  int   en_cnt;
  logic force_ready;
  logic ram_en;

  assign ram_en        = bus.ram_ren | bus.ram_wen;
  assign bus.ram_ready = force_ready | (ram_en && (en_cnt == lat - 1));
  assign bus.ram_load  = bus.ram_addr ^ LOAD_KEY;

  always @(posedge CLK or posedge RST) begin
    if (RST) en_cnt <= 0;
    else if (!ram_en || bus.ram_ready) en_cnt <= 0;
    else en_cnt <= en_cnt + 1;
  end

  typedef struct {
    bit          is_d;
    bit          wr;
    bit          drop;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t sb[$];
  int   checks, failures, cyc, en_len, exp_len, last_done;
  bit   gap_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_i(input logic [31:0] a, input bit drop);
    exp_t e;
    e.is_d = 1'b0; e.wr = 1'b0; e.drop = drop;
    e.addr = a; e.store = '0; e.load = a ^ LOAD_KEY;
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input bit wr, input logic [31:0] st, input bit drop);
    exp_t e;
    e.is_d = 1'b1; e.wr = wr; e.drop = drop;
    e.addr = a; e.store = st; e.load = wr ? 32'h0 : (a ^ LOAD_KEY);
    sb.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (RST) return;
    if (ram_en) begin
      if (sb.size() == 0) begin
        check("unexp_enable", 64'(ram_en), 64'(0));
      end else begin
        e = sb[0];
        check("ram_addr", 64'(bus.ram_addr), 64'(e.addr));
        check("ram_wen", 64'(bus.ram_wen), 64'(e.wr));
        check("ram_ren", 64'(bus.ram_ren), 64'(!e.wr));
        if (e.is_d && e.wr) check("ram_store", 64'(bus.ram_store), 64'(e.store));
      end
      en_len++;
    end
    if (bus.idone | bus.ddone) begin
      if (sb.size() == 0) begin
        check("unexp_done", 64'({bus.idone, bus.ddone}), 64'(0));
      end else begin
        e = sb.pop_front();
        check("done_port", 64'({bus.idone, bus.ddone}), e.is_d ? 64'(2'b01) : 64'(2'b10));
        if (e.is_d) begin
          check("dload", 64'(bus.dload), 64'(e.load));
          check("iload_quiet", 64'(bus.iload), 64'(0));
        end else begin
          check("iload", 64'(bus.iload), 64'(e.load));
          check("dload_quiet", 64'(bus.dload), 64'(0));
        end
        if (exp_len != 0) check("enable_cycles", 64'(en_len), 64'(exp_len));
        if (gap_chk && last_done >= 0) check("done_gap", 64'(cyc - last_done), 64'(2));
        last_done = cyc;
        if (e.drop) begin
          if (e.is_d) begin bus.dren = 1'b0; bus.dwen = 1'b0; end
          else bus.iren = 1'b0;
        end
      end
      en_len = 0;
    end else begin
      check("iload_idle", 64'(bus.iload), 64'(0));
      check("dload_idle", 64'(bus.dload), 64'(0));
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    mon();
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  task automatic wait_enable(input int budget);
    int n = 0;
    while (!ram_en && n < budget) begin
      tick();
      n++;
    end
    if (!ram_en) check("enable_timeout", 64'(ram_en), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; en_len = 0; exp_len = 0;
    last_done = -1; gap_chk = 1'b0; force_ready = 1'b0; lat = 1;
    bus.iren = 1'b0; bus.iaddr = '0; bus.dren = 1'b0; bus.dwen = 1'b0;
    bus.daddr = '0; bus.dstore = '0;
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_ram_ren", 64'(bus.ram_ren), 64'(0));
    check("rst_ram_wen", 64'(bus.ram_wen), 64'(0));
    check("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
    check("rst_ram_store", 64'(bus.ram_store), 64'(0));
    check("rst_idone", 64'(bus.idone), 64'(0));
    check("rst_iload", 64'(bus.iload), 64'(0));
    check("rst_ddone", 64'(bus.ddone), 64'(0));
    check("rst_dload", 64'(bus.dload), 64'(0));
    RST = 1'b0;

    // single fetch, RAM ready on the third enabled cycle
    lat = 3; exp_len = 3;
    push_i(32'h0000_0040, 1'b1);
    bus.iren = 1'b1; bus.iaddr = 32'h0000_0040;
    wait_empty(20);
    exp_len = 0;
    tick();
    check("idle_after_fetch", 64'(ram_en), 64'(0));

    // simultaneous fetch and data read: data first, fetch right after
    lat = 2;
    push_d(32'h0000_0048, 1'b0, 32'h0, 1'b1);
    push_i(32'h0000_0044, 1'b1);
    bus.iren = 1'b1; bus.iaddr = 32'h0000_0044;
    bus.dren = 1'b1; bus.daddr = 32'h0000_0048;
    wait_empty(30);
    tick();

    // starvation: two rounds of four data grants then one fetch, at full throughput
    lat = 1; gap_chk = 1'b1; last_done = -1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_d(32'h0000_0300, 1'b0, 32'h0, 1'b0);
      push_i(32'h0000_0500, 1'b0);
    end
    bus.iren = 1'b1; bus.iaddr = 32'h0000_0500;
    bus.dren = 1'b1; bus.daddr = 32'h0000_0300;
    wait_empty(60);
    bus.iren = 1'b0; bus.dren = 1'b0;
    gap_chk = 1'b0;
    tick();

    // dren and dwen together behave as a write
    lat = 2;
    push_d(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1'b1);
    bus.dren = 1'b1; bus.dwen = 1'b1;
    bus.daddr = 32'h0000_0100; bus.dstore = 32'hDEAD_BEEF;
    wait_empty(20);
    tick();

    // operands changed and request dropped mid-access
    lat = 4;
    push_d(32'h0000_0100, 1'b0, 32'h0, 1'b1);
    bus.dren = 1'b1; bus.dwen = 1'b0; bus.daddr = 32'h0000_0100;
    wait_enable(5);
    bus.daddr = 32'h0000_0200; bus.dstore = 32'h0000_1234; bus.dren = 1'b0;
    wait_empty(20);
    tick();

    // ram_ready while idle must not produce a done
    force_ready = 1'b1;
    repeat (3) begin
      tick();
      check("idle_ready_idone", 64'(bus.idone), 64'(0));
      check("idle_ready_ddone", 64'(bus.ddone), 64'(0));
    end
    force_ready = 1'b0;

    // reset during a fetch aborts it without a done pulse
    lat = 5;
    push_i(32'h0000_0080, 1'b1);
    bus.iren = 1'b1; bus.iaddr = 32'h0000_0080;
    wait_enable(5);
    tick();
    RST = 1'b1;
    #1;
    check("abort_ram_ren", 64'(bus.ram_ren), 64'(0));
    check("abort_ram_wen", 64'(bus.ram_wen), 64'(0));
    check("abort_idone", 64'(bus.idone), 64'(0));
    check("abort_ram_addr", 64'(bus.ram_addr), 64'(0));
    bus.iren = 1'b0;
    sb.delete();
    en_len = 0;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    check("post_reset_idle", 64'(ram_en), 64'(0));

    lat = 2;
    push_i(32'h0000_0084, 1'b1);
    bus.iren = 1'b1; bus.iaddr = 32'h0000_0084;
    wait_empty(20);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
